// File: rtl/bcd_to_binary_seq_if.sv
// Start/done handshake bundle for the sequential BCD-to-binary converter.
// With BCD_TO_BINARY_SIGN_EN defined, a neg input is added and binary widens by one bit.
interface bcd_to_binary_seq_if #(
  parameter int DIGITS    = 5,
  parameter int BIN_WIDTH = 17
);
`ifdef BCD_TO_BINARY_SIGN_EN
  localparam int OUT_W = BIN_WIDTH + 1;
  logic                neg;
`else
  localparam int OUT_W = BIN_WIDTH;
`endif
  logic                start;
  logic [4*DIGITS-1:0] bcd;
  logic [OUT_W-1:0]    binary;
  logic                busy;
  logic                done;
  logic                err;

`ifdef BCD_TO_BINARY_SIGN_EN
  modport master (output start, bcd, neg, input binary, busy, done, err);
  modport slave  (input start, bcd, neg, output binary, busy, done, err);
`else
  modport master (output start, bcd, input binary, busy, done, err);
  modport slave  (input start, bcd, output binary, busy, done, err);
`endif
endinterface

// File: rtl/bcd_to_binary_seq.sv
// Sequential reverse double-dabble: packed BCD to binary, one shift/adjust per clock.
// Optional signed result (two's complement, neg input) when BCD_TO_BINARY_SIGN_EN is defined.
module bcd_to_binary_seq #(
  parameter int DIGITS    = 5,
  parameter int BIN_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_to_binary_seq_if.slave    bus
);
  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_WIDTH;
  localparam int CNT_W  = $clog2(BIN_WIDTH + 1);
`ifdef BCD_TO_BINARY_SIGN_EN
  localparam int OUT_W  = BIN_WIDTH + 1;
`else
  localparam int OUT_W  = BIN_WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_WIDTH - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, CONV = 1'b1} state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WORK_W-1:0]  work_r;
  logic [WORK_W-1:0]  shift_s;
  logic [WORK_W-1:0]  work_next_s;
  logic [OUT_W-1:0]   binary_r;
  logic [OUT_W-1:0]   result_s;
  logic               busy_r;
  logic               done_r;
  logic               err_r;
  logic               bad_s;
`ifdef BCD_TO_BINARY_SIGN_EN
  logic               neg_r;
  logic [OUT_W-1:0]   mag_s;
`endif

  function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bad = bad | (v[4*i +: 4] > 4'd9);
    end
    return bad;
  endfunction

  // Inverse of the add-3 step: a digit that reached 8+ after the shift held a carry of 5.
  function automatic logic [3:0] adjust_digit(input logic [3:0] d);
    return (d >= 4'd8) ? (d - 4'd3) : d;
  endfunction

  // Next work value: shift right, then adjust every BCD nibble independently
  always_comb begin
    shift_s     = {1'b0, work_r[WORK_W-1:1]};
    work_next_s = shift_s;
    for (int i = 0; i < DIGITS; i++) begin
      work_next_s[BIN_WIDTH + 4*i +: 4] = adjust_digit(shift_s[BIN_WIDTH + 4*i +: 4]);
    end
    bad_s = has_bad_digit(bus.bcd);
  end

  // Final result taken from the bin_part of this iteration, negated on request
  always_comb begin
`ifdef BCD_TO_BINARY_SIGN_EN
    mag_s = {1'b0, work_next_s[BIN_WIDTH-1:0]};
    if (neg_r) begin
      result_s = ~mag_s + OUT_W'(1);
    end else begin
      result_s = mag_s;
    end
`else
    result_s = work_next_s[BIN_WIDTH-1:0];
`endif
  end

  // Control FSM, iteration datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      work_r   <= '0;
      binary_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
`ifdef BCD_TO_BINARY_SIGN_EN
      neg_r    <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            if (bad_s) begin
              binary_r <= '0;
              err_r    <= 1'b1;
              done_r   <= 1'b1;
            end else begin
              work_r  <= {bus.bcd, {BIN_WIDTH{1'b0}}};
              cnt_r   <= '0;
              err_r   <= 1'b0;
              busy_r  <= 1'b1;
              state_r <= CONV;
`ifdef BCD_TO_BINARY_SIGN_EN
              neg_r   <= bus.neg;
`endif
            end
          end
        end
        CONV: begin
          work_r <= work_next_s;
          cnt_r  <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_CNT) begin
            binary_r <= result_s;
            done_r   <= 1'b1;
            busy_r   <= 1'b0;
            state_r  <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.binary = binary_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.err    = err_r;
endmodule
